// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller for the combinational ALU.
//
// Accepts one instruction at a time over a valid/ready handshake, reads its
// operands from a 4-entry register file, drives the ALU through SETUP and EXEC,
// then writes the result and flags back in WB. One instruction per four cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready is high only in IDLE
//   instr[16:0]         {imm_sel, op[3:0], rd[1:0], rs[1:0], imm[7:0]}
//   alu_x/y/op          registered drive to the ALU
//   alu_z/zero/carry    ALU result and flags
//   res_valid/res_data  one-cycle writeback pulse and its value
//   flag_z/flag_c       registered flags from the last completed instruction
//   err_illegal         one-cycle pulse after an op-15 instruction is accepted
//   dbg_addr/dbg_data   combinational register-file read port
module alu_issue_ctrl #(
  parameter int unsigned        DATA_W  = 8,
  parameter logic [DATA_W-1:0]  REG_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [16:0]       instr,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              err_illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StSetup, StExec, StWb} state_e;

  localparam logic [3:0] OpAdd     = 4'd0;
  localparam logic [3:0] OpSub     = 4'd2;
  localparam logic [3:0] OpIllegal = 4'd15;

  state_e            state_q;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] x_q;
  logic [1:0]        rd_q;

  // Instruction field decode
  logic              in_imm_sel;
  logic [3:0]        in_op;
  logic [1:0]        in_rd;
  logic [1:0]        in_rs;
  logic [7:0]        in_imm;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;

  assign in_imm_sel = instr[16];
  assign in_op      = instr[15:12];
  assign in_rd      = instr[11:10];
  assign in_rs      = instr[9:8];
  assign in_imm     = instr[7:0];
  assign in_x       = regs_q[in_rd];
  assign in_y       = in_imm_sel ? DATA_W'(in_imm) : regs_q[in_rs];

  assign instr_ready = (state_q == StIdle);
  assign dbg_data    = regs_q[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < 4; i++) regs_q[i] <= REG_RST;
      x_q         <= '0;
      rd_q        <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_op      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      res_valid   <= 1'b0;
      err_illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            if (in_op == OpIllegal) begin
              // Rejected in place: nothing latched, ALU drive left untouched.
              err_illegal <= 1'b1;
            end else begin
              alu_op  <= in_op;
              x_q     <= in_x;
              rd_q    <= in_rd;
              // Inverted x guarantees an operand change into the ALU, so it
              // re-evaluates under the new op even if operands repeat.
              alu_x   <= ~in_x;
              alu_y   <= in_y;
              state_q <= StSetup;
            end
          end
        end
        StSetup: begin
          alu_x   <= x_q;
          state_q <= StExec;
        end
        StExec: begin
          // ALU inputs have been stable for the whole EXEC cycle.
          res_valid <= 1'b1;
          res_data  <= alu_z;
          state_q   <= StWb;
        end
        StWb: begin
          // Register write lands on this edge, so dbg_data shows the old
          // value throughout WB. ALU inputs are still held, so flags match.
          regs_q[rd_q] <= res_data;
          flag_z       <= alu_zero;
          flag_c       <= ((alu_op == OpAdd) || (alu_op == OpSub)) && alu_carry;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule
